// File: rtl/vga_fb_pkg.sv
// Shared defaults, arbiter state type and index-width helper for the
// frame-buffer arbiter.
package vga_fb_pkg;

  localparam int FB_ADDR_W    = 15;
  localparam int FB_DATA_W    = 12;
  localparam int FB_NREQ      = 3;
  localparam int FB_MAX_BURST = 4;
  localparam int BURST_W      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // A requester index always needs at least one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_rr_pick.sv
// Wrapped priority search: the first set request at or above ptr,
// wrapping from NREQ-1 back to 0.
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic             valid
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
      idx = sum[PTR_W-1:0];
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port RGB444 frame-buffer arbiter: display reads always win, drawing
// writers share the remaining slots round-robin with a bounded burst.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int NREQ      = FB_NREQ,
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W,
  parameter int MAX_BURST = FB_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     dbg_state
);

  localparam int PTR_W = idx_w(NREQ);

  arb_state_t         state;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   ptr;
  logic [BURST_W-1:0] burst_cnt;
  logic               rd_pend;

  logic               owner_keep;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   search_ptr;
  logic [NREQ-1:0]    pick_oh;
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  assign dbg_state = (state == OWN);

  assign owner_keep = (state == OWN) && req[owner] &&
                      (burst_cnt < BURST_W'(MAX_BURST));
  assign next_ptr   = (owner == PTR_W'(NREQ-1)) ? '0 : owner + 1'b1;
  // When ownership ends this cycle, search from owner+1 right away so the
  // next writer is granted without a bubble.
  assign search_ptr = (state == OWN) ? next_ptr : ptr;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (search_ptr),
    .winner (pick_oh),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick_oh[i]) pick_idx = PTR_W'(i);
  end

  // Handshake: a writer holds req/addr/data until gnt; the word transfers at
  // the edge where req[i] && gnt[i]. gnt is combinational, never without req.
  always_comb begin
    gnt = '0;
    if (rst_n && !rd_req) begin
      if (owner_keep)      gnt[owner] = 1'b1;
      else if (pick_valid) gnt = pick_oh;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_pend   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      rd_pend  <= mem_en && !mem_we;
      rd_valid <= rd_pend;
      if (rd_pend) rd_data <= mem_rdata;

      if (rd_req) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= rd_addr;
      end else if (|gnt) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_data;
      end else begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end

      // Read cycles freeze ownership and the burst count.
      if (!rd_req) begin
        if (owner_keep) begin
          burst_cnt <= burst_cnt + 1'b1;
        end else begin
          if (state == OWN) ptr <= next_ptr;
          if (pick_valid) begin
            state     <= OWN;
            owner     <= pick_idx;
            burst_cnt <= BURST_W'(1);
          end else begin
            state     <= IDLE;
            burst_cnt <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a memory-op scoreboard and a
// read-return scoreboard.
module tb_vga_fb_arbiter;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 12;
  localparam int W      = 1 + ADDR_W + DATA_W;

  logic                   clk;
  logic                   rst_n;
  logic                   rd_req;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   rd_valid;
  logic [DATA_W-1:0]      rd_data;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic                   mem_en;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;
  logic                   dbg_state;

  vga_fb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: reads return a fixed address pattern one cycle later.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return a[11:0] ^ {a[14:12], 9'h000} ^ 12'h5A3;
  endfunction

  initial mem_rdata = '0;
  always @(posedge clk)
    if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] rd_q[$];
  int                rd_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [W-1:0] e;
    logic [DATA_W-1:0] d;
    int c;
    #1;
    if (mem_en) begin
      if (exp_q.size() == 0) begin
        chk("mem_unexpected", 32'(mem_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("mem_we", 32'(mem_we), 32'(e[W-1]));
        chk("mem_addr", 32'(mem_addr), 32'(e[W-2:DATA_W]));
        if (e[W-1]) chk("mem_wdata", 32'(mem_wdata), 32'(e[DATA_W-1:0]));
      end
    end
    if (rd_valid) begin
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        d = rd_q.pop_front();
        c = rd_cyc_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(d));
        chk("rd_latency", 32'(cyc), 32'(c));
      end
    end
  end

  // ---------------- driver ----------------
  logic [ADDR_W-1:0] cur_addr[NREQ];
  logic [DATA_W-1:0] cur_data[NREQ];

  task automatic drive_words();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = cur_addr[i];
      req_data[i*DATA_W +: DATA_W] = cur_data[i];
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [ADDR_W-1:0] ra,
                      input logic [NREQ-1:0] rq, input logic [NREQ-1:0] eg);
    rd_req  = r;
    rd_addr = ra;
    req     = rq;
    drive_words();
    #1;
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    if (r) begin
      exp_q.push_back({1'b0, ra, {DATA_W{1'b0}}});
      rd_q.push_back(pat(ra));
      rd_cyc_q.push_back(cyc + 3);
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (eg[i]) exp_q.push_back({1'b1, cur_addr[i], cur_data[i]});
    end
    @(posedge clk);
    #2;
    chk({tag, "_memq"}, 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < NREQ; i++) begin
      if (eg[i] && rq[i]) begin
        cur_addr[i] = cur_addr[i] + 1'b1;
        cur_data[i] = DATA_W'($urandom_range(0, 4095));
      end
    end
    @(negedge clk);
  endtask

  // Reset cycle: in-flight reads are dropped, so their expectations go too.
  task automatic rst_step(input string tag, input logic r, input logic [NREQ-1:0] rq);
    rst_n   = 1'b0;
    rd_req  = r;
    rd_addr = ADDR_W'($urandom_range(0, 19199));
    req     = rq;
    drive_words();
    #1;
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    rd_q.delete();
    rd_cyc_q.delete();
    @(posedge clk);
    #2;
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  logic [DATA_W-1:0]    sdat[4];
  logic [3*NREQ-1:0]    ctab;
  logic [NREQ-1:0]      cgnt;

  initial begin
    sdat = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
    rst_n   = 1'b0;
    rd_req  = 1'b0;
    rd_addr = '0;
    req     = '0;
    for (int i = 0; i < NREQ; i++) begin
      cur_addr[i] = ADDR_W'(16'h0100 * (i + 1));
      cur_data[i] = DATA_W'($urandom_range(0, 4095));
    end
    drive_words();
    @(negedge clk);

    // Reset held with everything requesting.
    for (int k = 0; k < 3; k++) rst_step("reset", 1'b1, 3'b111);
    rst_n = 1'b1;

    // All contending: 4 beats each, rotating, no idle cycles.
    for (int k = 0; k < 13; k++) begin
      cgnt = (k < 4) ? 3'b001 : (k < 8) ? 3'b010 : (k < 12) ? 3'b100 : 3'b001;
      step("contend", 1'b0, '0, 3'b111, cgnt);
    end
    step("contend_end", 1'b0, '0, 3'b000, 3'b000);

    // Requester 1 streams a known burst.
    for (int k = 0; k < 4; k++) begin
      cur_addr[1] = ADDR_W'(16'h0010 + k);
      cur_data[1] = sdat[k];
      step("single", 1'b0, '0, 3'b010, 3'b010);
    end
    step("single_end", 1'b0, '0, 3'b000, 3'b000);

    // Read lands in requester 0's burst; it still gets 4 writes.
    step("rdburst_b1", 1'b0, '0, 3'b011, 3'b001);
    step("rdburst_rd", 1'b1, 15'h1234, 3'b011, 3'b000);
    for (int k = 0; k < 3; k++) step("rdburst_b", 1'b0, '0, 3'b011, 3'b001);
    step("rdburst_rot", 1'b0, '0, 3'b011, 3'b010);

    // Lone requester is re-granted right after its burst limit.
    for (int k = 0; k < 3; k++) step("lone", 1'b0, '0, 3'b010, 3'b010);
    step("lone_regrant", 1'b0, '0, 3'b010, 3'b010);
    step("lone_end", 1'b0, '0, 3'b000, 3'b000);

    // Continuous reads block the waiting writer.
    for (int k = 0; k < 8; k++)
      step("creads", 1'b1, ADDR_W'($urandom_range(0, 19199)), 3'b010, 3'b000);
    step("creads_gnt", 1'b0, '0, 3'b010, 3'b010);
    step("creads_idle", 1'b0, '0, 3'b000, 3'b000);
    step("creads_idle", 1'b0, '0, 3'b000, 3'b000);

    // Reset during requester 2's 3rd beat, with a read in flight.
    ctab = 9'b100_000_100;
    for (int k = 0; k < 3; k++) begin
      cgnt = ctab[3*k +: 3];
      step("midrst", (k == 1), 15'h0ABC, 3'b111, cgnt);
    end
    rst_step("midrst_rst", 1'b0, 3'b111);
    rst_n = 1'b1;
    step("midrst_after", 1'b0, '0, 3'b111, 3'b001);

    for (int k = 0; k < 3; k++) step("drain", 1'b0, '0, 3'b000, 3'b000);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
